// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: result-class, Tuse and mul/div codes shared by the hazard controller,
// plus the per-stage tag record and the single-source dependency test.
package hazard_ctrl_pkg;

   localparam logic [2:0] RES_NO  = 3'd0;
   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;
   localparam logic [2:0] RES_PC  = 3'd3;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MULT = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;

   typedef struct packed {
      logic [4:0] a3;
      logic [2:0] res;
      logic [1:0] tnew;
   } tag_t;

   // W only publishes destination and class; its Tnew is always 0
   typedef struct packed {
      logic [4:0] a3;
      logic [2:0] res;
   } wtag_t;

   localparam tag_t  TAG_BUBBLE  = '{a3: 5'd0, res: RES_NO, tnew: 2'd0};
   localparam wtag_t WTAG_BUBBLE = '{a3: 5'd0, res: RES_NO};

   function automatic logic dep_stall(input logic [4:0] src, input logic [1:0] tuse, input tag_t t);
      return (src != 5'd0) && (src == t.a3) && (tuse != TUSE_NONE) && (tuse < t.tnew);
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: HI/LO busy counter, loaded when a mult/div leaves E and counting down to 0.
module md_busy_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] md_op_e,
   output logic       md_busy
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (md_op_e == MD_MULT) ? CW'(MULT_CYCLES) :
              (md_op_e != MD_NONE) ? CW'(DIV_CYCLES)  :
              (cnt_q != '0)        ? cnt_q - CW'(1)   : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign md_busy = (cnt_q != '0) || (md_op_e != MD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: producer-side tag pipeline (E/M/W) and D-stage stall generation.
// Define MD_STALL_EN to add the HI/LO busy tracking for multiply/divide.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [1:0] tuse_rs_d,
   input  logic [1:0] tuse_rt_d,
   input  logic [4:0] a3_d,
   input  logic [2:0] res_d,
   input  logic [1:0] tnew_d,
   input  logic [1:0] md_op_d,
   input  logic       md_use_d,
   output logic       stall,
   output logic [4:0] a3_e,
   output logic [4:0] a3_m,
   output logic [4:0] a3_w,
   output logic [2:0] res_e,
   output logic [2:0] res_m,
   output logic [2:0] res_w,
   output logic       md_busy
);

   tag_t  e_q, e_d, m_q, m_d;
   wtag_t w_q, w_d;
   logic  reg_stall, md_stall;

   always_comb begin
      reg_stall = dep_stall(rs_d, tuse_rs_d, e_q) || dep_stall(rs_d, tuse_rs_d, m_q) ||
                  dep_stall(rt_d, tuse_rt_d, e_q) || dep_stall(rt_d, tuse_rt_d, m_q);
      stall = reg_stall || md_stall;
      e_d = stall ? TAG_BUBBLE : tag_t'{a3: a3_d, res: res_d, tnew: tnew_d};
      m_d = tag_t'{a3: e_q.a3, res: e_q.res, tnew: (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0};
      w_d = wtag_t'{a3: m_q.a3, res: m_q.res};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= TAG_BUBBLE;
         m_q <= TAG_BUBBLE;
         w_q <= WTAG_BUBBLE;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign a3_e  = e_q.a3;
   assign a3_m  = m_q.a3;
   assign a3_w  = w_q.a3;
   assign res_e = e_q.res;
   assign res_m = m_q.res;
   assign res_w = w_q.res;

`ifdef MD_STALL_EN
   logic [1:0] md_op_e_q, md_op_e_d;

   assign md_op_e_d = stall ? MD_NONE : md_op_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) md_op_e_q <= MD_NONE;
      else       md_op_e_q <= md_op_e_d;
   end

   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_cnt (
      .clk     (clk),
      .reset   (reset),
      .md_op_e (md_op_e_q),
      .md_busy (md_busy)
   );

   assign md_stall = md_use_d && md_busy;
`else
   localparam int unsigned unused_md_cycles = MULT_CYCLES + DIV_CYCLES;
   logic unused_md_in;

   assign unused_md_in = ^{md_op_d, md_use_d};
   assign md_busy      = 1'b0;
   assign md_stall     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus checked against an issue-history model.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

`ifdef MD_STALL_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;

   logic       clk = 1'b0, reset = 1'b1;
   logic [4:0] rs_d, rt_d, a3_d;
   logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d, md_op_d;
   logic [2:0] res_d;
   logic       md_use_d;
   logic       stall, md_busy;
   logic [4:0] a3_e, a3_m, a3_w;
   logic [2:0] res_e, res_m, res_w;

   hazard_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d),
      .tuse_rt_d(tuse_rt_d), .a3_d(a3_d), .res_d(res_d), .tnew_d(tnew_d),
      .md_op_d(md_op_d), .md_use_d(md_use_d), .stall(stall), .a3_e(a3_e), .a3_m(a3_m),
      .a3_w(a3_w), .res_e(res_e), .res_m(res_m), .res_w(res_w), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   // model: the list of what entered E at each edge, newest last
   typedef struct {
      int a3;
      int res;
      int tnew;
      int md;
   } ins_t;

   ins_t hist[$];
   int   edge_n = 0, md_exit = 0, md_len = 0;
   bit   have_md = 1'b0;
   int   total = 0, bad = 0;
   logic obs_stall;

   function automatic ins_t bubble();
      ins_t b;
      b.a3 = 0; b.res = int'(RES_NO); b.tnew = 0; b.md = 0;
      return b;
   endfunction

   function automatic ins_t stage(input int age);
      int idx = hist.size() - 1 - age;
      return (idx < 0) ? bubble() : hist[idx];
   endfunction

   function automatic bit needs(input int src, input int tuse, input int age);
      ins_t p = stage(age);
      int tn = p.tnew - age;
      if (tn < 0) tn = 0;
      return src != 0 && src == p.a3 && tuse < tn;
   endfunction

   function automatic bit exp_busy();
      if (!MD) return 1'b0;
      return stage(0).md != 0 || (have_md && edge_n <= md_exit + md_len - 1);
   endfunction

   function automatic bit exp_stall();
      bit s = 1'b0;
      for (int a = 0; a < 2; a++)
         s |= needs(int'(rs_d), int'(tuse_rs_d), a) || needs(int'(rt_d), int'(tuse_rt_d), a);
      return s || (md_use_d && exp_busy());
   endfunction

   task automatic model_clear();
      hist.delete();
      have_md = 1'b0;
   endtask

   task automatic model_edge(input bit st);
      ins_t d;
      if (reset) model_clear();
      else begin
         if (MD && stage(0).md != 0) begin
            md_exit = edge_n + 1;
            md_len  = (stage(0).md == 1) ? MULT_C : DIV_C;
            have_md = 1'b1;
         end
         d.a3 = int'(a3_d); d.res = int'(res_d); d.tnew = int'(tnew_d); d.md = MD ? int'(md_op_d) : 0;
         hist.push_back(st ? bubble() : d);
         if (hist.size() > 3) void'(hist.pop_front());
      end
      edge_n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_d(input int rs, input int trs, input int rt, input int trt, input int a3,
                        input logic [2:0] res, input int tn, input logic [1:0] mdop, input bit mduse);
      rs_d = 5'(rs); tuse_rs_d = 2'(trs); rt_d = 5'(rt); tuse_rt_d = 2'(trt);
      a3_d = 5'(a3); res_d = res; tnew_d = 2'(tn); md_op_d = mdop; md_use_d = mduse;
   endtask

   task automatic nop();
      set_d(0, 3, 0, 3, 0, RES_NO, 0, MD_NONE, 1'b0);
   endtask

   task automatic tick();
      bit es;
      #3;
      es = exp_stall();
      chk("stall", 32'(stall), 32'(es));
      chk("md_busy", 32'(md_busy), 32'(exp_busy()));
      chk("a3_e", 32'(a3_e), stage(0).a3);
      chk("a3_m", 32'(a3_m), stage(1).a3);
      chk("a3_w", 32'(a3_w), stage(2).a3);
      chk("res_e", 32'(res_e), stage(0).res);
      chk("res_m", 32'(res_m), stage(1).res);
      chk("res_w", 32'(res_w), stage(2).res);
      obs_stall = stall;
      @(posedge clk);
      model_edge(es);
      #1;
   endtask

   task automatic issue(input string tag, input int exp_n);
      int n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (obs_stall === 1'b0) break;
         n++;
      end
      chk(tag, 32'(n), 32'(exp_n));
   endtask

   initial begin
      set_d(5, 0, 6, 1, 5, RES_ALU, 1, MD_DIV, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b0;
      nop(); tick(); tick();
      // load then ALU consumer
      set_d(0, 3, 0, 3, 8, RES_DM, 2, MD_NONE, 1'b0); tick();
      set_d(8, 1, 0, 3, 9, RES_ALU, 1, MD_NONE, 1'b0); issue("lw_tuse1", 1);
      nop(); tick(); tick(); tick();
      // load then branch consumer
      set_d(0, 3, 0, 3, 8, RES_DM, 2, MD_NONE, 1'b0); tick();
      set_d(8, 0, 0, 3, 0, RES_NO, 0, MD_NONE, 1'b0); issue("lw_tuse0", 2);
      nop(); tick(); tick();
      set_d(0, 3, 0, 3, 7, RES_DM, 2, MD_NONE, 1'b0); tick();
      set_d(1, 3, 7, 1, 2, RES_ALU, 1, MD_NONE, 1'b0); issue("lw_rt_tuse1", 1);
      set_d(0, 3, 0, 3, 9, RES_ALU, 1, MD_NONE, 1'b0); tick();
      set_d(9, 0, 0, 3, 0, RES_NO, 0, MD_NONE, 1'b0); issue("alu_tuse0", 1);
      set_d(0, 3, 0, 3, 0, RES_ALU, 1, MD_NONE, 1'b0); tick();
      set_d(0, 0, 0, 0, 4, RES_ALU, 1, MD_NONE, 1'b0); issue("zero_reg", 0);
      nop(); tick(); tick();
      // div then mflo
      set_d(0, 3, 0, 3, 0, RES_NO, 0, MD_DIV, 1'b1); tick();
      set_d(0, 3, 0, 3, 10, RES_ALU, 1, MD_NONE, 1'b1); issue("div_mflo", MD ? DIV_C + 1 : 0);
      chk("mflo_in_e", 32'(a3_e), 32'd10);
      set_d(0, 3, 0, 3, 0, RES_NO, 0, MD_MULT, 1'b1); tick();
      set_d(0, 3, 0, 3, 11, RES_ALU, 1, MD_NONE, 1'b1); issue("mult_mfhi", MD ? MULT_C + 1 : 0);
      // reset four cycles into a divide
      set_d(0, 3, 0, 3, 0, RES_NO, 0, MD_DIV, 1'b1); tick();
      nop(); for (int i = 0; i < 4; i++) tick();
      set_d(0, 3, 0, 3, 12, RES_ALU, 1, MD_NONE, 1'b1);
      #1 reset = 1'b1;
      model_clear();
      #1;
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      tick();
      reset = 1'b0;
      issue("post_rst", 0);
      for (int i = 0; i < 400; i++) begin
         set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 3'($urandom_range(0, 3)), $urandom_range(0, 2),
               ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : MD_NONE,
               $urandom_range(0, 3) == 0);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Producer-side hazard controller for the five-stage pipeline. It carries each in-flight instruction's destination register, result class and remaining latency (Tnew) down the E/M/W stages, and publishes those tags to the forwarding selector. It also compares D-stage source needs (Tuse) against the tags and raises a stall when forwarding cannot cover the dependency. With the multiply/divide option compiled in, it also tracks HI/LO busy.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- rs_d, rt_d  in  5 each  D-stage source register numbers
- tuse_rs_d, tuse_rt_d  in  2 each  cycles until the operand is consumed; 3 means unused
- a3_d  in  5  D-stage destination register; 0 means no write
- res_d  in  3  result class (`RES_NO/`RES_ALU/`RES_DM/`RES_PC)
- tnew_d  in  2  Tnew the instruction will have on entering E
- md_op_d  in  2  0 none, 1 mult-class, 2 div-class
- md_use_d  in  1  D instruction reads/writes HI/LO
- stall  out  1  freeze PC and IF/ID; bubble ID/EX
- a3_e, a3_m, a3_w  out  5 each  registered destination tags
- res_e, res_m, res_w  out  3 each  registered result-class tags
- md_busy  out  1  HI/LO unit busy

## Operation
- Tag pipeline: three registered stages of {a3, res, tnew}, plus md_op in E.
- Each clock: W<=M, M<=E with tnew_m = sat(tnew_e-1) (floor 0), and E<=D tags when stall=0.
- When stall=1, E is loaded with a bubble: a3=0, res=`RES_NO, tnew=0, md_op=0.
- Register-dependency stall is combinational on the current registers:
  - stall if rs_d!=0 && rs_d==a3_e && tuse_rs_d<tnew_e
  - stall if rs_d!=0 && rs_d==a3_m && tuse_rs_d<tnew_m
  - same two conditions for rt_d/tuse_rt_d
- W never causes a stall; its tnew is always 0.
- A tag with a3=0 never matches.
- Multiply/divide counter (`MD_STALL_EN`):
  - A nonzero md_op_e loads the counter with MULT_CYCLES or DIV_CYCLES on the next edge.
  - The counter decrements to 0 and saturates there.
  - md_busy = (counter!=0) || (md_op_e!=0).
  - stall also asserts when md_use_d && md_busy.
- Counter reload: a new md_op_e (only possible when md_use_d did not stall) reloads the counter. md_busy stays high through the reload.

## Timing
- Reset (async, immediate): all a3_*=0, res_*=`RES_NO, tnew_*=0, md_op_e=0, counter=0. Hence stall=0 and md_busy=0 during and after reset.
- Reset mid-divide aborts the count; md_busy drops in the same cycle.
- Tag latency: D inputs appear on a3_e/res_e one cycle after a non-stalled edge, on *_m one cycle later, on *_w two cycles later.
- stall has zero latency from the D inputs.
- A load (tnew_d=2) followed by a consumer with tuse=0 stalls exactly 2 cycles. With tuse=1 it stalls exactly 1 cycle.
- div in E at edge N: md_busy is high from N-1 (while in E) through N+DIV_CYCLES-1, and low from N+DIV_CYCLES.
- Simultaneous register and md stall conditions: stall asserts once; the bubble is inserted once.

## Configuration
- MD_STALL_EN defined:
  - Counter, md_op_e and the md_use_d term are built.
  - md_busy behaves as described under Operation.
- MD_STALL_EN undefined:
  - No counter and no md_op_e register; md_op_d and md_use_d are ignored.
  - md_busy is tied to 0; stall covers register hazards only.

## Structure
- Shared constants go in define.v, alongside the existing `MF_*` selector codes used by the forwarding selector:
  - `RES_NO`=0, `RES_ALU`=1, `RES_DM`=2, `RES_PC`=3
  - `TUSE_NONE`=3, `MD_NONE`=0, `MD_MULT`=1, `MD_DIV`=2
- One sub-module: md_busy_cnt, holding the counter and busy logic. It is instantiated only under MD_STALL_EN.

## Test plan
- Reset, then hold reset high while driving valid tags. Expect all outputs 0/`RES_NO` and stall=0 throughout.
- lw $8 (a3_d=8, res=`RES_DM`, tnew_d=2), then addu using rs=8 with tuse=1. Expect stall high for exactly 1 cycle, then a3_m=8 with res_m=`RES_DM`.
- lw $8, then beq with rs=8 and tuse=0. Expect stall for 2 cycles, and the E bubble shows a3_e=0 each stalled cycle.
- addu $0 (a3=0), then consumer rs=0 with tuse=0. Expect no stall.
- With MD_STALL_EN: div in E, then mflo (md_use_d=1) in D. Expect stall for 11 consecutive cycles (1 in E + DIV_CYCLES=10). Expect md_busy low on cycle 12, with mflo entering E.
- Assert reset 4 cycles into a div. Expect md_busy=0 and stall=0 immediately, with no residual stall after reset release.
